// File: rtl/iob_uart_console_pkg.sv
// Shared definitions for the tester-UART console engine: FSM encoding and
// the default native-bus register map of the UART.
package iob_uart_console_pkg;

  typedef enum logic [3:0] {
    ST_INIT_SR1  = 4'd0,
    ST_INIT_SR0  = 4'd1,
    ST_INIT_DIV  = 4'd2,
    ST_INIT_TXEN = 4'd3,
    ST_INIT_RXEN = 4'd4,
    ST_IDLE      = 4'd5,
    ST_POLL_TX   = 4'd6,
    ST_WR_TX     = 4'd7,
    ST_POLL_RX   = 4'd8,
    ST_RD_RX     = 4'd9
  } state_t;

  // write addresses
  localparam int DEF_A_SOFTRESET = 0;
  localparam int DEF_A_DIV       = 1;
  localparam int DEF_A_TXDATA    = 2;
  localparam int DEF_A_TXEN      = 3;
  localparam int DEF_A_RXEN      = 4;
  // read addresses
  localparam int DEF_A_TXREADY   = 0;
  localparam int DEF_A_RXREADY   = 1;
  localparam int DEF_A_RXDATA    = 2;

  localparam logic LAST_TX = 1'b0;
  localparam logic LAST_RX = 1'b1;

  function automatic logic [3:0] strb_for(input logic write);
    return write ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/iob_uart_console_if.sv
// Native request/ready bus between the console engine and the tester UART.
interface iob_uart_console_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/iob_uart_console_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and wrap-bit
// full/empty detection; a pop on a full FIFO frees the slot for a same-cycle push.
module iob_uart_console_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [0:DEPTH-1];
  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign pop_data  = mem[rptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/iob_uart_console.sv
// Host engine for the tester UART: runs the init register sequence, then
// round-robins between sending queued bench bytes and collecting received bytes.
module iob_uart_console
  import iob_uart_console_pkg::*;
#(
  parameter int          ADDR_W      = 3,
  parameter int          DATA_W      = 32,
  parameter logic [15:0] DIV_VAL     = 16'd100,
  parameter int          FIFO_W      = 3,
  parameter int          TIMEOUT     = 1024,
  parameter int          A_SOFTRESET = DEF_A_SOFTRESET,
  parameter int          A_DIV       = DEF_A_DIV,
  parameter int          A_TXDATA    = DEF_A_TXDATA,
  parameter int          A_TXEN      = DEF_A_TXEN,
  parameter int          A_RXEN      = DEF_A_RXEN,
  parameter int          A_TXREADY   = DEF_A_TXREADY,
  parameter int          A_RXREADY   = DEF_A_RXREADY,
  parameter int          A_RXDATA    = DEF_A_RXDATA
) (
  input  logic                  clk,
  input  logic                  rst,
  iob_uart_console_if.master    bus,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic                  init_done,
  output logic                  bus_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state_r;
  logic              m_valid_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic [3:0]        m_wstrb_r;
  logic              init_done_r;
  logic              bus_err_r;
  logic              last_r;
  logic [TMO_W-1:0]  tmo_r;

  logic [ADDR_W-1:0] req_addr_s;
  logic [DATA_W-1:0] req_wdata_s;
  logic              req_write_s;
  logic              done_s;
  logic              tx_pop_s;
  logic              rx_push_s;
  logic [7:0]        tx_head_s;
  logic              tx_full_s;
  logic              tx_empty_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic              unused_rdata;

  assign bus.m_valid  = m_valid_r;
  assign bus.m_addr   = m_addr_r;
  assign bus.m_wdata  = m_wdata_r;
  assign bus.m_wstrb  = m_wstrb_r;
  assign init_done    = init_done_r;
  assign bus_err      = bus_err_r;
  assign tx_ready     = !tx_full_s;
  assign rx_valid     = !rx_empty_s;
  assign unused_rdata = ^bus.m_rdata[DATA_W-1:8];

  assign done_s    = m_valid_r && bus.m_ready;
  assign tx_pop_s  = done_s && (state_r == ST_WR_TX);
  assign rx_push_s = done_s && (state_r == ST_RD_RX);

  iob_uart_console_fifo #(.W(8), .AW(FIFO_W)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && !tx_full_s),
    .push_data (tx_data),
    .pop       (tx_pop_s),
    .pop_data  (tx_head_s),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  iob_uart_console_fifo #(.W(8), .AW(FIFO_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (bus.m_rdata[7:0]),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full_s),
    .empty     (rx_empty_s)
  );

  // Request decode: the access each bus state performs
  always_comb begin
    req_addr_s  = '0;
    req_wdata_s = '0;
    req_write_s = 1'b0;
    case (state_r)
      ST_INIT_SR1: begin
        req_addr_s  = ADDR_W'(A_SOFTRESET);
        req_wdata_s = DATA_W'(32'd1);
        req_write_s = 1'b1;
      end
      ST_INIT_SR0: begin
        req_addr_s  = ADDR_W'(A_SOFTRESET);
        req_write_s = 1'b1;
      end
      ST_INIT_DIV: begin
        req_addr_s  = ADDR_W'(A_DIV);
        req_wdata_s = {{(DATA_W-16){1'b0}}, DIV_VAL};
        req_write_s = 1'b1;
      end
      ST_INIT_TXEN: begin
        req_addr_s  = ADDR_W'(A_TXEN);
        req_wdata_s = DATA_W'(32'd1);
        req_write_s = 1'b1;
      end
      ST_INIT_RXEN: begin
        req_addr_s  = ADDR_W'(A_RXEN);
        req_wdata_s = DATA_W'(32'd1);
        req_write_s = 1'b1;
      end
      ST_POLL_TX: req_addr_s = ADDR_W'(A_TXREADY);
      ST_WR_TX: begin
        req_addr_s  = ADDR_W'(A_TXDATA);
        req_wdata_s = {{(DATA_W-8){1'b0}}, tx_head_s};
        req_write_s = 1'b1;
      end
      ST_POLL_RX: req_addr_s = ADDR_W'(A_RXREADY);
      ST_RD_RX:   req_addr_s = ADDR_W'(A_RXDATA);
      default:    req_addr_s = '0;
    endcase
  end

  // Main FSM: request issue, completion, timeout and IDLE arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT_SR1;
      m_valid_r   <= 1'b0;
      m_addr_r    <= '0;
      m_wdata_r   <= '0;
      m_wstrb_r   <= 4'h0;
      init_done_r <= 1'b0;
      bus_err_r   <= 1'b0;
      last_r      <= LAST_TX;
      tmo_r       <= '0;
    end else if (m_valid_r) begin
      if (bus.m_ready) begin
        m_valid_r <= 1'b0;
        tmo_r     <= '0;
        case (state_r)
          ST_INIT_SR1:  state_r <= ST_INIT_SR0;
          ST_INIT_SR0:  state_r <= ST_INIT_DIV;
          ST_INIT_DIV:  state_r <= ST_INIT_TXEN;
          ST_INIT_TXEN: state_r <= ST_INIT_RXEN;
          ST_INIT_RXEN: begin
            init_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
          ST_POLL_TX: begin
            if (bus.m_rdata[0]) begin
              state_r <= ST_WR_TX;
            end else begin
              state_r <= ST_IDLE;
              last_r  <= LAST_TX;
            end
          end
          ST_WR_TX: begin
            state_r <= ST_IDLE;
            last_r  <= LAST_TX;
          end
          ST_POLL_RX: begin
            if (bus.m_rdata[0]) begin
              state_r <= ST_RD_RX;
            end else begin
              state_r <= ST_IDLE;
              last_r  <= LAST_RX;
            end
          end
          ST_RD_RX: begin
            state_r <= ST_IDLE;
            last_r  <= LAST_RX;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
        // Abandon the access; no FIFO side effect happens because done_s stays low
        m_valid_r <= 1'b0;
        bus_err_r <= 1'b1;
        tmo_r     <= '0;
        state_r   <= ST_IDLE;
      end else begin
        tmo_r <= tmo_r + TMO_W'(1);
      end
    end else if (state_r == ST_IDLE) begin
      if (init_done_r) begin
        if (!tx_empty_s && !rx_full_s) begin
          state_r <= (last_r == LAST_RX) ? ST_POLL_TX : ST_POLL_RX;
        end else if (!tx_empty_s) begin
          state_r <= ST_POLL_TX;
        end else if (!rx_full_s) begin
          state_r <= ST_POLL_RX;
        end else begin
          state_r <= ST_IDLE;
        end
      end
    end else begin
      // Entering a bus state always follows a dropped m_valid, giving the idle gap
      m_valid_r <= 1'b1;
      m_addr_r  <= req_addr_s;
      m_wdata_r <= req_wdata_s;
      m_wstrb_r <= strb_for(req_write_s);
      tmo_r     <= '0;
    end
  end

endmodule
